// File: rtl/otter_dcdr_pipe_if.sv
// Fetch-to-execute bundle for otter_dcdr_pipe: instruction handshake in, decoded controls out.
// master = upstream/downstream environment, slave = the decoder.
interface otter_dcdr_pipe_if #(
  parameter int unsigned ILL_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_ir;
  logic                 in_br_eq;
  logic                 in_br_lt;
  logic                 in_br_ltu;
  logic                 int_taken;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           alu_fun;
  logic [1:0]           alu_srcA;
  logic [2:0]           alu_srcB;
  logic [2:0]           pcSource;
  logic [1:0]           rf_wr_sel;
  logic                 reg_wr;
  logic                 mem_we;
  logic                 mem_rden;
  logic                 csr_we;
  logic                 mret;
  logic                 int_ack;
  logic                 illegal;
  logic [ILL_CNT_W-1:0] ill_cnt;

  modport master (
    output in_valid, in_ir, in_br_eq, in_br_lt, in_br_ltu, int_taken, out_ready,
    input  in_ready, out_valid, alu_fun, alu_srcA, alu_srcB, pcSource, rf_wr_sel,
           reg_wr, mem_we, mem_rden, csr_we, mret, int_ack, illegal, ill_cnt
  );

  modport slave (
    input  in_valid, in_ir, in_br_eq, in_br_lt, in_br_ltu, int_taken, out_ready,
    output in_ready, out_valid, alu_fun, alu_srcA, alu_srcB, pcSource, rf_wr_sel,
           reg_wr, mem_we, mem_rden, csr_we, mret, int_ack, illegal, ill_cnt
  );
endinterface

// File: rtl/otter_dcdr_pipe.sv
// Pipelined OTTER decoder with skid buffer, interrupt latch and saturating illegal counter.
// Define OTTER_CSR_EN to decode the SYSTEM opcode (csrrw/csrrs/csrrc/mret).
module otter_dcdr_pipe #(
  parameter int unsigned REG_OUT   = 1,
  parameter int unsigned ILL_CNT_W = 8
) (
  input logic              CLK,
  input logic              RST,
  otter_dcdr_pipe_if.slave bus
);
  typedef enum logic [6:0] {
    OP_RTYPE  = 7'b0110011,
    OP_IALU   = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  typedef struct packed {
    logic [3:0] alu_fun;
    logic [1:0] alu_srcA;
    logic [2:0] alu_srcB;
    logic [2:0] pcSource;
    logic [1:0] rf_wr_sel;
    logic       reg_wr;
    logic       mem_we;
    logic       mem_rden;
    logic       csr_we;
    logic       mret;
    logic       int_ack;
    logic       illegal;
  } ctrl_t;

  opcode_e              opc;
  logic [2:0]           f3;
  logic                 ir30;
  ctrl_t                dec;
  ctrl_t                out_c;
  logic                 take;
  logic                 bad;
  logic                 accept;
  logic                 out_xfer;
  logic                 int_pend_q, int_pend_d;
  logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  assign opc  = opcode_e'(bus.in_ir[6:0]);
  assign f3   = bus.in_ir[14:12];
  assign ir30 = bus.in_ir[30];

  // Register/immediate index bits belong to the datapath, not the decoder.
  logic unused_ir_bits;
`ifdef OTTER_CSR_EN
  assign unused_ir_bits = ^{bus.in_ir[31], bus.in_ir[27:15], bus.in_ir[11:7]};
`else
  assign unused_ir_bits = ^{bus.in_ir[31:28], bus.in_ir[27:15], bus.in_ir[11:7]};
`endif

  always_comb begin
    dec  = '0;
    take = 1'b0;
    bad  = 1'b0;
    case (opc)
      OP_RTYPE: begin
        dec.alu_fun   = {ir30 & ((f3 == 3'b000) | (f3 == 3'b101)), f3};
        dec.rf_wr_sel = 2'd3;
        dec.reg_wr    = 1'b1;
      end
      OP_IALU: begin
        dec.alu_fun   = {ir30 & (f3 == 3'b101), f3};
        dec.alu_srcB  = 3'd1;
        dec.rf_wr_sel = 2'd3;
        dec.reg_wr    = 1'b1;
      end
      OP_LOAD: begin
        dec.alu_srcB  = 3'd1;
        dec.mem_rden  = 1'b1;
        dec.rf_wr_sel = 2'd2;
        dec.reg_wr    = 1'b1;
      end
      OP_STORE: begin
        dec.alu_srcB = 3'd2;
        dec.mem_we   = 1'b1;
      end
      OP_BRANCH: begin
        case (f3)
          3'b000:  take = bus.in_br_eq;
          3'b001:  take = !bus.in_br_eq;
          3'b100:  take = bus.in_br_lt;
          3'b101:  take = !bus.in_br_lt;
          3'b110:  take = bus.in_br_ltu;
          3'b111:  take = !bus.in_br_ltu;
          default: bad  = 1'b1;
        endcase
        dec.pcSource = take ? 3'd2 : 3'd0;
      end
      OP_JAL: begin
        dec.pcSource = 3'd3;
        dec.reg_wr   = 1'b1;
      end
      OP_JALR: begin
        bad          = (f3 != 3'b000);
        dec.pcSource = 3'd1;
        dec.alu_srcB = 3'd1;
        dec.reg_wr   = 1'b1;
      end
      OP_LUI: begin
        dec.alu_fun   = 4'b1001;
        dec.alu_srcA  = 2'd1;
        dec.rf_wr_sel = 2'd3;
        dec.reg_wr    = 1'b1;
      end
      OP_AUIPC: begin
        dec.alu_srcA  = 2'd1;
        dec.alu_srcB  = 3'd3;
        dec.rf_wr_sel = 2'd3;
        dec.reg_wr    = 1'b1;
      end
`ifdef OTTER_CSR_EN
      OP_SYSTEM: begin
        case (f3)
          3'b001, 3'b010, 3'b011: begin
            dec.alu_fun   = (f3 == 3'b010) ? 4'b0110 : (f3 == 3'b011) ? 4'b0111 : 4'b0000;
            dec.alu_srcA  = (f3 == 3'b011) ? 2'd2 : 2'd0;
            dec.alu_srcB  = 3'd4;
            dec.rf_wr_sel = 2'd1;
            dec.csr_we    = 1'b1;
            dec.reg_wr    = 1'b1;
          end
          3'b000: begin
            bad          = (bus.in_ir[29:28] != 2'b11);
            dec.pcSource = 3'd5;
            dec.mret     = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
`endif
      default: bad = 1'b1;
    endcase
    // A pending interrupt takes precedence over whatever word is being accepted.
    if (int_pend_q) begin
      dec          = '0;
      dec.pcSource = 3'd4;
      dec.int_ack  = 1'b1;
    end else if (bad) begin
      dec          = '0;
      dec.pcSource = 3'd4;
      dec.illegal  = 1'b1;
    end
  end

  if (REG_OUT != 0) begin : g_reg
    ctrl_t main_q, main_d, skid_q, skid_d;
    logic  main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;

    assign bus.in_ready  = !skid_vld_q;
    assign accept        = bus.in_valid && !skid_vld_q;
    assign out_xfer      = main_vld_q && bus.out_ready;
    assign out_c         = main_q;
    assign bus.out_valid = main_vld_q;

    // in_ready is low whenever skid is full, so accept and a skid refill never coincide.
    always_comb begin
      main_d     = main_q;
      main_vld_d = main_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (out_xfer) begin
        if (skid_vld_q) begin
          main_d     = skid_q;
          skid_vld_d = 1'b0;
        end else begin
          main_vld_d = accept;
          if (accept) main_d = dec;
        end
      end else if (!main_vld_q) begin
        main_vld_d = accept;
        if (accept) main_d = dec;
      end else if (accept) begin
        skid_d     = dec;
        skid_vld_d = 1'b1;
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        main_q     <= '0;
        main_vld_q <= 1'b0;
        skid_q     <= '0;
        skid_vld_q <= 1'b0;
      end else begin
        main_q     <= main_d;
        main_vld_q <= main_vld_d;
        skid_q     <= skid_d;
        skid_vld_q <= skid_vld_d;
      end
    end
  end else begin : g_comb
    assign bus.in_ready  = bus.out_ready;
    assign accept        = bus.in_valid && bus.out_ready;
    assign out_xfer      = accept;
    assign out_c         = dec;
    assign bus.out_valid = bus.in_valid;
  end

  always_comb begin
    int_pend_d = (int_pend_q && !accept) || bus.int_taken;
    ill_cnt_d  = ill_cnt_q;
    if (out_xfer && out_c.illegal && !(&ill_cnt_q)) ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      int_pend_q <= 1'b0;
      ill_cnt_q  <= '0;
    end else begin
      int_pend_q <= int_pend_d;
      ill_cnt_q  <= ill_cnt_d;
    end
  end

  assign bus.alu_fun   = out_c.alu_fun;
  assign bus.alu_srcA  = out_c.alu_srcA;
  assign bus.alu_srcB  = out_c.alu_srcB;
  assign bus.pcSource  = out_c.pcSource;
  assign bus.rf_wr_sel = out_c.rf_wr_sel;
  assign bus.reg_wr    = out_c.reg_wr;
  assign bus.mem_we    = out_c.mem_we;
  assign bus.mem_rden  = out_c.mem_rden;
  assign bus.csr_we    = out_c.csr_we;
  assign bus.mret      = out_c.mret;
  assign bus.int_ack   = out_c.int_ack;
  assign bus.illegal   = out_c.illegal;
  assign bus.ill_cnt   = ill_cnt_q;
endmodule

// File: tb/tb_otter_dcdr_pipe.sv
// Bench for otter_dcdr_pipe: directed vector table, handshake corner sequences, and random
// traffic scored against a mnemonic-level model of a 2-deep, 1-cycle-latency decode stage.
module tb_otter_dcdr_pipe;
  localparam int unsigned ILL_W   = 8;
  localparam int unsigned ILL_MAX = (1 << ILL_W) - 1;
  localparam logic [6:0] F_RW   = 7'b1000000;
  localparam logic [6:0] F_WE   = 7'b0100000;
  localparam logic [6:0] F_RD   = 7'b0010000;
  localparam logic [6:0] F_CSR  = 7'b0001000;
  localparam logic [6:0] F_MRET = 7'b0000100;
  localparam logic [6:0] F_ACK  = 7'b0000010;
  localparam logic [6:0] F_ILL  = 7'b0000001;

  typedef struct packed {
    logic [3:0] alu_fun;
    logic [1:0] alu_srcA;
    logic [2:0] alu_srcB;
    logic [2:0] pcSource;
    logic [1:0] rf_wr_sel;
    logic       reg_wr;
    logic       mem_we;
    logic       mem_rden;
    logic       csr_we;
    logic       mret;
    logic       int_ack;
    logic       illegal;
  } ctl_t;

  typedef struct {
    logic [31:0] ir;
    logic        eq;
    logic        lt;
    logic        ltu;
    ctl_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  ctl_t        mq[$];
  bit          m_pend = 1'b0;
  int unsigned m_cnt = 0;

  otter_dcdr_pipe_if #(.ILL_CNT_W(ILL_W)) bus ();
  otter_dcdr_pipe #(.REG_OUT(1), .ILL_CNT_W(ILL_W)) dut (.CLK(clk), .RST(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic ctl_t mk(input logic [3:0] alu, input logic [1:0] sa, input logic [2:0] sb,
                              input logic [2:0] pc, input logic [1:0] rf, input logic [6:0] fl);
    ctl_t c;
    c = {alu, sa, sb, pc, rf, fl};
    return c;
  endfunction

  function automatic ctl_t pack_out();
    ctl_t c;
    c = {bus.alu_fun, bus.alu_srcA, bus.alu_srcB, bus.pcSource, bus.rf_wr_sel, bus.reg_wr,
         bus.mem_we, bus.mem_rden, bus.csr_we, bus.mret, bus.int_ack, bus.illegal};
    return c;
  endfunction

  // Name the instruction the way an assembler would, then derive controls from the name.
  function automatic string mnem(input logic [31:0] ir);
    logic [2:0] f;
    f = ir[14:12];
    case (ir[6:0])
      7'b0110111: return "lui";
      7'b0010111: return "auipc";
      7'b1101111: return "jal";
      7'b1100111: return (f == 3'd0) ? "jalr" : "illegal";
      7'b0000011: return "load";
      7'b0100011: return "store";
      7'b1100011: case (f)
        3'd0: return "beq";  3'd1: return "bne";  3'd4: return "blt";
        3'd5: return "bge";  3'd6: return "bltu"; 3'd7: return "bgeu";
        default: return "illegal";
      endcase
      7'b0010011: case (f)
        3'd0: return "addi"; 3'd1: return "slli"; 3'd2: return "slti"; 3'd3: return "sltiu";
        3'd4: return "xori"; 3'd5: return ir[30] ? "srai" : "srli";
        3'd6: return "ori";  default: return "andi";
      endcase
      7'b0110011: case (f)
        3'd0: return ir[30] ? "sub" : "add"; 3'd1: return "sll"; 3'd2: return "slt";
        3'd3: return "sltu"; 3'd4: return "xor"; 3'd5: return ir[30] ? "sra" : "srl";
        3'd6: return "or";   default: return "and";
      endcase
`ifdef OTTER_CSR_EN
      7'b1110011: case (f)
        3'd1: return "csrrw"; 3'd2: return "csrrs"; 3'd3: return "csrrc";
        3'd0: return (ir[29:28] == 2'b11) ? "mret" : "illegal";
        default: return "illegal";
      endcase
`endif
      default: return "illegal";
    endcase
  endfunction

  function automatic logic [3:0] alu_code(input string mn);
    case (mn)
      "sub":                    return 4'b1000;
      "sll", "slli":            return 4'b0001;
      "slt", "slti":            return 4'b0010;
      "sltu", "sltiu":          return 4'b0011;
      "xor", "xori":            return 4'b0100;
      "srl", "srli":            return 4'b0101;
      "sra", "srai":            return 4'b1101;
      "or", "ori", "csrrs":     return 4'b0110;
      "and", "andi", "csrrc":   return 4'b0111;
      "lui":                    return 4'b1001;
      default:                  return 4'b0000;
    endcase
  endfunction

  function automatic ctl_t model(input logic [31:0] ir, input logic eq, input logic lt, input logic ltu);
    string mn;
    mn = mnem(ir);
    case (mn)
      "add", "sub", "sll", "slt", "sltu", "xor", "srl", "sra", "or", "and":
        return mk(alu_code(mn), 2'd0, 3'd0, 3'd0, 2'd3, F_RW);
      "addi", "slli", "slti", "sltiu", "xori", "srli", "srai", "ori", "andi":
        return mk(alu_code(mn), 2'd0, 3'd1, 3'd0, 2'd3, F_RW);
      "load":  return mk(4'b0000, 2'd0, 3'd1, 3'd0, 2'd2, F_RW | F_RD);
      "store": return mk(4'b0000, 2'd0, 3'd2, 3'd0, 2'd0, F_WE);
      "beq":   return mk(4'b0000, 2'd0, 3'd0, eq   ? 3'd2 : 3'd0, 2'd0, 7'd0);
      "bne":   return mk(4'b0000, 2'd0, 3'd0, !eq  ? 3'd2 : 3'd0, 2'd0, 7'd0);
      "blt":   return mk(4'b0000, 2'd0, 3'd0, lt   ? 3'd2 : 3'd0, 2'd0, 7'd0);
      "bge":   return mk(4'b0000, 2'd0, 3'd0, !lt  ? 3'd2 : 3'd0, 2'd0, 7'd0);
      "bltu":  return mk(4'b0000, 2'd0, 3'd0, ltu  ? 3'd2 : 3'd0, 2'd0, 7'd0);
      "bgeu":  return mk(4'b0000, 2'd0, 3'd0, !ltu ? 3'd2 : 3'd0, 2'd0, 7'd0);
      "jal":   return mk(4'b0000, 2'd0, 3'd0, 3'd3, 2'd0, F_RW);
      "jalr":  return mk(4'b0000, 2'd0, 3'd1, 3'd1, 2'd0, F_RW);
      "lui":   return mk(4'b1001, 2'd1, 3'd0, 3'd0, 2'd3, F_RW);
      "auipc": return mk(4'b0000, 2'd1, 3'd3, 3'd0, 2'd3, F_RW);
      "csrrw", "csrrs":
               return mk(alu_code(mn), 2'd0, 3'd4, 3'd0, 2'd1, F_RW | F_CSR);
      "csrrc": return mk(alu_code(mn), 2'd2, 3'd4, 3'd0, 2'd1, F_RW | F_CSR);
      "mret":  return mk(4'b0000, 2'd0, 3'd0, 3'd5, 2'd0, F_MRET);
      default: return mk(4'b0000, 2'd0, 3'd0, 3'd4, 2'd0, F_ILL);
    endcase
  endfunction

  // Scoreboard: accepted words queue up, at most two in flight, each appears one cycle later.
  initial begin
    ctl_t e;
    bit   acc;
    forever begin
      @(negedge clk);
      if (rst) begin
        mq.delete();
        m_pend = 1'b0;
        m_cnt  = 0;
      end else begin
        chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < 2));
        chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        if (bus.out_valid && bus.out_ready) begin
          if (mq.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
          else begin
            e = mq.pop_front();
            chk("out_ctl", 32'(pack_out()), 32'(e));
            chk("ill_cnt", 32'(bus.ill_cnt), m_cnt);
            if (e.illegal && m_cnt != ILL_MAX) m_cnt++;
          end
        end
        acc = bus.in_valid && bus.in_ready;
        if (acc) begin
          if (m_pend) mq.push_back(mk(4'b0000, 2'd0, 3'd0, 3'd4, 2'd0, F_ACK));
          else        mq.push_back(model(bus.in_ir, bus.in_br_eq, bus.in_br_lt, bus.in_br_ltu));
        end
        m_pend = (m_pend && !acc) || bus.int_taken;
      end
    end
  end

  task automatic send(input logic [31:0] ir, input logic eq, input logic lt, input logic ltu,
                      output int unsigned cyc);
    bit acc;
    bus.in_valid  = 1'b1;
    bus.in_ir     = ir;
    bus.in_br_eq  = eq;
    bus.in_br_lt  = lt;
    bus.in_br_ltu = ltu;
    cyc = 0;
    acc = 1'b0;
    while (!acc && cyc < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t         tv[$];
  ctl_t         ill_t;
  ctl_t         lw_t;
  int unsigned  cyc;
  logic [6:0]   ops[11];

  initial begin
    ill_t = mk(4'b0000, 2'd0, 3'd0, 3'd4, 2'd0, F_ILL);
    lw_t  = mk(4'b0000, 2'd0, 3'd1, 3'd0, 2'd2, F_RW | F_RD);
    tv.push_back('{32'h00000033, 1'b0, 1'b0, 1'b0, mk(4'b0000, 0, 0, 0, 3, F_RW)});  // add
    tv.push_back('{32'h40000033, 1'b0, 1'b0, 1'b0, mk(4'b1000, 0, 0, 0, 3, F_RW)});  // sub
    tv.push_back('{32'h00005033, 1'b0, 1'b0, 1'b0, mk(4'b0101, 0, 0, 0, 3, F_RW)});  // srl
    tv.push_back('{32'h40005033, 1'b0, 1'b0, 1'b0, mk(4'b1101, 0, 0, 0, 3, F_RW)});  // sra
    tv.push_back('{32'h00000013, 1'b0, 1'b0, 1'b0, mk(4'b0000, 0, 1, 0, 3, F_RW)});  // addi
    tv.push_back('{32'h40005013, 1'b0, 1'b0, 1'b0, mk(4'b1101, 0, 1, 0, 3, F_RW)});  // srai
    tv.push_back('{32'h00004013, 1'b0, 1'b0, 1'b0, mk(4'b0100, 0, 1, 0, 3, F_RW)});  // xori
    tv.push_back('{32'h00007033, 1'b0, 1'b0, 1'b0, mk(4'b0111, 0, 0, 0, 3, F_RW)});  // and
    tv.push_back('{32'h00005063, 1'b0, 1'b1, 1'b0, mk(4'b0000, 0, 0, 0, 0, 7'd0)});  // bge, lt
    tv.push_back('{32'h00007063, 1'b0, 1'b0, 1'b0, mk(4'b0000, 0, 0, 2, 0, 7'd0)});  // bgeu, !ltu
    tv.push_back('{32'h00001063, 1'b1, 1'b0, 1'b0, mk(4'b0000, 0, 0, 0, 0, 7'd0)});  // bne, eq
    tv.push_back('{32'h00000063, 1'b1, 1'b0, 1'b0, mk(4'b0000, 0, 0, 2, 0, 7'd0)});  // beq, eq
    tv.push_back('{32'h00004063, 1'b0, 1'b1, 1'b0, mk(4'b0000, 0, 0, 2, 0, 7'd0)});  // blt, lt
    tv.push_back('{32'h00002003, 1'b0, 1'b0, 1'b0, lw_t});                           // lw
    tv.push_back('{32'h00002023, 1'b0, 1'b0, 1'b0, mk(4'b0000, 0, 2, 0, 0, F_WE)});  // sw
    tv.push_back('{32'h0000006F, 1'b0, 1'b0, 1'b0, mk(4'b0000, 0, 0, 3, 0, F_RW)});  // jal
    tv.push_back('{32'h00000067, 1'b0, 1'b0, 1'b0, mk(4'b0000, 0, 1, 1, 0, F_RW)});  // jalr
    tv.push_back('{32'h00000037, 1'b0, 1'b0, 1'b0, mk(4'b1001, 1, 0, 0, 3, F_RW)});  // lui
    tv.push_back('{32'h00000017, 1'b0, 1'b0, 1'b0, mk(4'b0000, 1, 3, 0, 3, F_RW)});  // auipc
    tv.push_back('{32'h00002063, 1'b1, 1'b1, 1'b1, ill_t});                          // branch f3=010
    tv.push_back('{32'h00001067, 1'b0, 1'b0, 1'b0, ill_t});                          // jalr f3=001
    tv.push_back('{32'h00000000, 1'b0, 1'b0, 1'b0, ill_t});                          // opcode 0
`ifdef OTTER_CSR_EN
    tv.push_back('{32'h30200073, 1'b0, 1'b0, 1'b0, mk(4'b0000, 0, 0, 5, 0, F_MRET)});
    tv.push_back('{32'h34001073, 1'b0, 1'b0, 1'b0, mk(4'b0000, 0, 4, 0, 1, F_RW | F_CSR)});
    tv.push_back('{32'h34002073, 1'b0, 1'b0, 1'b0, mk(4'b0110, 0, 4, 0, 1, F_RW | F_CSR)});
    tv.push_back('{32'h34003073, 1'b0, 1'b0, 1'b0, mk(4'b0111, 2, 4, 0, 1, F_RW | F_CSR)});
`else
    tv.push_back('{32'h30200073, 1'b0, 1'b0, 1'b0, ill_t});
    tv.push_back('{32'h34001073, 1'b0, 1'b0, 1'b0, ill_t});
`endif
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011, 7'b0000000};

    bus.in_valid  = 1'b0;
    bus.in_ir     = '0;
    bus.in_br_eq  = 1'b0;
    bus.in_br_lt  = 1'b0;
    bus.in_br_ltu = 1'b0;
    bus.int_taken = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ctl", 32'(pack_out()), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_ill_cnt", 32'(bus.ill_cnt), 32'd0);

    // Back-to-back table: every word accepted in one cycle, visible right after.
    foreach (tv[i]) begin
      send(tv[i].ir, tv[i].eq, tv[i].lt, tv[i].ltu, cyc);
      chk("tv_latency", cyc, 32'd1);
      chk("tv_out_valid", 32'(bus.out_valid), 32'd1);
      chk($sformatf("tv%0d_ctl", i), 32'(pack_out()), 32'(tv[i].exp));
    end
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: three words offered while out_ready is low for three cycles.
    bus.out_ready = 1'b0;
    send(32'h00000033, 1'b0, 1'b0, 1'b0, cyc);
    send(32'h40000033, 1'b0, 1'b0, 1'b0, cyc);
    chk("bp_in_ready_drop", 32'(bus.in_ready), 32'd0);
    chk("bp_head_add", 32'(pack_out()), 32'(tv[0].exp));
    bus.in_ir = 32'h00004033;
    @(posedge clk);
    #1;
    chk("bp_still_full", 32'(bus.in_ready), 32'd0);
    chk("bp_head_stable", 32'(pack_out()), 32'(tv[0].exp));
    bus.out_ready = 1'b1;
    send(32'h00004033, 1'b0, 1'b0, 1'b0, cyc);
    chk("bp_third_wait", cyc, 32'd2);
    chk("bp_tail_xor", 32'(pack_out()), 32'(mk(4'b0100, 0, 0, 0, 3, F_RW)));
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_drained", 32'(mq.size()), 32'd0);

    // Interrupt pulse with no instruction, then lw four cycles later.
    bus.int_taken = 1'b1;
    @(posedge clk);
    #1 bus.int_taken = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    send(32'h00002003, 1'b0, 1'b0, 1'b0, cyc);
    chk("int_token", 32'(pack_out()), 32'(mk(4'b0000, 0, 0, 4, 0, F_ACK)));
    send(32'h00002003, 1'b0, 1'b0, 1'b0, cyc);
    chk("int_cleared_lw", 32'(pack_out()), 32'(lw_t));
    bus.in_valid = 1'b0;

    // 300 illegal words saturate the counter.
    for (int i = 0; i < 300; i++) begin
      send(32'h00000000, 1'b0, 1'b0, 1'b0, cyc);
      chk("ill_token", 32'(pack_out()), 32'(ill_t));
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("ill_cnt_sat", 32'(bus.ill_cnt), ILL_MAX);

    // Reset with both slots full and an interrupt latched.
    bus.out_ready = 1'b0;
    send(32'h00000033, 1'b0, 1'b0, 1'b0, cyc);
    send(32'h00000013, 1'b0, 1'b0, 1'b0, cyc);
    bus.in_valid  = 1'b0;
    bus.int_taken = 1'b1;
    @(posedge clk);
    #1 bus.int_taken = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mrst_ctl", 32'(pack_out()), 32'd0);
    chk("mrst_ill_cnt", 32'(bus.ill_cnt), 32'd0);
    bus.out_ready = 1'b1;
    send(32'h00002003, 1'b0, 1'b0, 1'b0, cyc);
    chk("mrst_no_int", 32'(pack_out()), 32'(lw_t));
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Random traffic against the scoreboard.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 10)];
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_ir     = w;
      bus.in_br_eq  = $urandom_range(0, 1) == 1;
      bus.in_br_lt  = $urandom_range(0, 1) == 1;
      bus.in_br_ltu = $urandom_range(0, 1) == 1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.int_taken = ($urandom_range(0, 15) == 0);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.int_taken = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rand_drained", 32'(mq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/otter_dcdr_pipe.md
# otter_dcdr_pipe

Pipelined, handshaked successor to the OTTER combinational decoder. It sits between fetch and execute and decodes a full 32-bit instruction plus its branch-condition flags into registered control signals behind a valid/ready interface with a skid buffer. It adds these behaviours:

- interrupt latching;
- CSR/mret decode;
- illegal-instruction detection, with a saturating counter.

## Interface
Parameters:
- REG_OUT, default 1, selects the output path.
  - 1: registered output with skid buffer, 1-cycle latency.
  - 0: combinational pass-through, 0-cycle latency; in_ready = out_ready.
- ILL_CNT_W, default 8, is the width of the saturating illegal-instruction counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- in_valid  in  1  instruction present
- in_ready  out  1  block can accept
- in_ir  in  32  instruction word
- in_br_eq, in_br_lt, in_br_ltu  in  1 each  branch flags for in_ir's operands
- int_taken  in  1  interrupt request pulse
- out_valid  out  1  decoded controls present
- out_ready  in  1  execute can accept
- alu_fun  out  4  add 0000, sub 1000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, sra 1101, or 0110, and 0111, lui 1001
- alu_srcA  out  2  0 rs1, 1 U-imm, 2 ~rs1
- alu_srcB  out  3  0 rs2, 1 I-imm, 2 S-imm, 3 PC, 4 CSR
- pcSource  out  3  0 PC+4, 1 jalr, 2 branch, 3 jal, 4 mtvec, 5 mepc
- rf_wr_sel  out  2  0 PC+4, 1 CSR, 2 mem, 3 ALU
- reg_wr, mem_we, mem_rden, csr_we, mret, int_ack, illegal  out  1 each
- ill_cnt  out  ILL_CNT_W  illegal-instruction count

## Operation
Decode (unlisted outputs are 0):
- R-type: rf_wr_sel 3, reg_wr 1. alu_fun is selected by funct3. ir30 selects sub for funct3=000 and sra for funct3=101; srl is 0101 when ir30=0.
- I-ALU: srcB 1, rf_wr_sel 3, reg_wr 1. srai/srli selection uses ir30.
- Load: srcB 1, add, mem_rden 1, rf_wr_sel 2, reg_wr 1.
- Store: srcB 2, add, mem_we 1.
- Branch: pcSource 2 when the condition holds, else 0.
  - beq: eq; bne: !eq; blt: lt; bge: !lt; bltu: ltu; bgeu: !ltu.
  - funct3 010/011 is illegal.
- jal: pcSource 3, rf_wr_sel 0, reg_wr 1.
- jalr (funct3 000): pcSource 1, srcB 1, rf_wr_sel 0, reg_wr 1.
- lui: srcA 1, alu_fun 1001, rf_wr_sel 3, reg_wr 1.
- auipc: srcA 1, srcB 3, add, rf_wr_sel 3, reg_wr 1.
- Illegal instruction: any other opcode/funct3 combination. Outputs illegal=1 and pcSource=4, with all write enables 0.

Interrupt latch:
- int_taken sets int_pend. int_pend holds until the next accepted instruction.
- That instruction is replaced by an interrupt token: pcSource 4, int_ack 1, all write enables 0, illegal 0.
- int_pend clears on that acceptance. A new int_taken arriving in the same cycle is re-latched (set wins).

Illegal counter:
- Increments when an illegal token transfers on the output (out_valid && out_ready).
- Saturates at all-ones.

Skid buffer (REG_OUT=1):
- Two slots: main and skid.
- in_ready = !skid_full.
- An input transfer while main is full and out_ready=0 fills skid.
- On an output transfer, skid moves to main.

## Timing
- Reset values: all outputs 0, out_valid 0, in_ready 1, int_pend 0, ill_cnt 0, both slots empty.
- RST asserted mid-transfer discards both slots and the latched interrupt.
- Latency with REG_OUT=1: 1 cycle from in_valid&&in_ready to out_valid. Sustains 1 instruction/cycle when out_ready is held high.
- Control outputs are stable while out_valid && !out_ready.
- out_valid never drops without a transfer.
- Branch flags are sampled with in_ir at acceptance and are not re-evaluated later.

## Configuration
OTTER_CSR_EN:
- Defined:
  - SYSTEM opcode 1110011 decodes.
  - csrrw: srcA 0, srcB 4, rf_wr_sel 1, csr_we 1, reg_wr 1.
  - csrrs: or; csrrc: and with srcA 2.
  - mret (funct3 000, ir[29:28]=11): pcSource 5, mret 1.
- Undefined: SYSTEM is illegal; csr_we and mret are tied to 0.

## Test plan
- Back-to-back add/sub/srl/sra/addi with out_ready=1 produce alu_fun 0000, 1000, 0101, 1101, 0000 one cycle after each acceptance, with no bubbles.
- bge with lt=1, eq=0 gives pcSource 0. bgeu with ltu=0 gives 2. bne with eq=1 gives 0.
- out_ready low for 3 cycles while 3 instructions are offered:
  - in_ready drops after the 2nd is accepted.
  - The outputs drain in order once out_ready rises; no loss or duplication.
- int_taken pulses with no instruction; 4 cycles later lw is accepted:
  - the output is an int_ack=1, pcSource=4 token with mem_rden=0;
  - int_pend then clears.
- 300 illegal opcodes (0000000) with ILL_CNT_W=8 leave ill_cnt=255. Each token has illegal=1, pcSource=4, reg_wr=0.
- With OTTER_CSR_EN, mret gives pcSource 5 and mret=1. Without it, the same word gives illegal=1.
